// File: rtl/alu_uart_interface.sv
// -----------------------------------------------------------------------------
// alu_uart_interface
//
// Sequencing stage between a UART receiver, a combinational ALU and a UART
// transmitter. Three received bytes are collected in order (operand A,
// operand B, opcode) and held stable on the ALU inputs. One cycle later the
// ALU result is captured into the TX byte register, a one-cycle start pulse
// is issued, and the block then waits for transmit completion before it
// accepts the next operand A.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_rx_data      received byte, valid while i_rx_done = 1
//   i_rx_done      one-cycle pulse, new byte on i_rx_data
//   i_alu_result   combinational ALU output
//   i_tx_done      one-cycle pulse, transmitter finished its byte
//   o_dato_A       registered operand A to the ALU
//   o_dato_B       registered operand B to the ALU
//   o_OP           registered opcode to the ALU (low NB_OP bits of byte 3)
//   o_tx_data      registered result byte to the transmitter
//   o_tx_start     one-cycle start pulse to the transmitter
//   o_busy         high while a result is being computed or sent
//
// state      | meaning
// -----------+------------------------------------------------------------
// WAIT_A     | idle, next received byte is operand A
// WAIT_B     | next received byte is operand B
// WAIT_OP    | next received byte is the opcode
// CALC       | ALU inputs settled, capture result into TX byte register
// SEND       | o_tx_start high for this single cycle
// WAIT_TX    | transmitter busy, hold everything until i_tx_done
// -----------------------------------------------------------------------------
module alu_uart_interface #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_dato_A,
  output logic [NB_DATA-1:0] o_dato_B,
  output logic [NB_OP-1:0]   o_OP,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_CALC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  state_t             state_q,   state_d;
  logic [NB_DATA-1:0] dato_a_q,  dato_a_d;
  logic [NB_DATA-1:0] dato_b_q,  dato_b_d;
  logic [NB_OP-1:0]   op_q,      op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_WAIT_A;
      dato_a_q  <= '0;
      dato_b_q  <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      dato_a_q  <= dato_a_d;
      dato_b_q  <= dato_b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Operand and opcode registers only move in the three receive states, so a
  // byte arriving while a result is in flight is simply lost and the ALU
  // inputs stay valid for the whole transmission.
  always_comb begin
    state_d   = state_q;
    dato_a_d  = dato_a_q;
    dato_b_d  = dato_b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;

    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          dato_a_d = i_rx_data;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          dato_b_d = i_rx_data;
          state_d  = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          op_d    = i_rx_data[NB_OP-1:0];
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // o_OP was updated on the previous edge; the ALU output now reflects it.
        tx_data_d = i_alu_result;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_d = ST_WAIT_A;
        end
      end
      default: begin
        state_d = ST_WAIT_A;
      end
    endcase
  end

  assign o_dato_A   = dato_a_q;
  assign o_dato_B   = dato_b_q;
  assign o_OP       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = (state_q == ST_SEND);
  assign o_busy     = (state_q == ST_CALC) || (state_q == ST_SEND) ||
                      (state_q == ST_WAIT_TX);

endmodule
